// File: rtl/aq_djpeg_seq.sv
// aq_djpeg_seq: holds the JPEG decoder in reset between frames, tracks decode progress and reports frame completion
module aq_djpeg_seq #(
  parameter int RST_CYCLES = 4,
  parameter int TO_W       = 24
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            START,
  input  logic            ABORT,
  input  logic [TO_W-1:0] TIMEOUT_LIMIT,
  input  logic            IRQ_CLR,
  output logic            DEC_RSTN,
  input  logic            DEC_IDLE,
  input  logic            DEC_VALID,
  input  logic [15:0]     DEC_WIDTH,
  input  logic [15:0]     DEC_HEIGHT,
  input  logic [15:0]     DEC_PIXELX,
  input  logic [15:0]     DEC_PIXELY,
  output logic            BUSY,
  output logic            DONE,
  output logic [1:0]      STATUS,
  output logic            IRQ,
  output logic [31:0]     PIX_CNT,
  output logic            FRAME_LAST
);
  typedef enum logic [2:0] {S_IDLE, S_RST, S_WAIT, S_RUN, S_END} state_e;
  localparam logic [1:0] ST_OK = 2'd0, ST_TO = 2'd1, ST_UR = 2'd2, ST_AB = 2'd3;
  localparam logic [7:0] RST_INIT = 8'(RST_CYCLES - 1);
  state_e          state_q, state_d;
  logic [7:0]      rcnt_q, rcnt_d;
  logic [TO_W-1:0] wd_q, wd_d, wd_inc;
  logic [31:0]     pix_cnt_q, pix_cnt_d;
  logic [1:0]      status_q, status_d;
  logic            stall_q, stall_d, irq_q, irq_d, last_q, last_d;
  logic            active, stalled, last_pix, to_hit;
  always_comb begin
    active    = state_q == S_WAIT || state_q == S_RUN;
    stalled   = DEC_IDLE && !DEC_VALID;
    last_pix  = DEC_VALID && DEC_PIXELX == DEC_WIDTH - 16'd1 && DEC_PIXELY == DEC_HEIGHT - 16'd1;
    wd_inc    = wd_q + TO_W'(1);
    to_hit    = TIMEOUT_LIMIT != '0 && !DEC_VALID && wd_inc == TIMEOUT_LIMIT;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    status_d  = status_q;
    pix_cnt_d = active && DEC_VALID ? pix_cnt_q + 32'd1 : pix_cnt_q;
    stall_d   = 1'b0;
    last_d    = 1'b0;
    if (state_q == S_IDLE) begin
      if (START) begin
        state_d   = S_RST;
        rcnt_d    = RST_INIT;
        pix_cnt_d = '0;
        status_d  = ST_OK;
      end
    end else if (state_q == S_END) state_d = S_IDLE;
    else if (ABORT) begin
      state_d  = S_END;
      status_d = ST_AB;
    end else if (state_q == S_RST) begin
      state_d = rcnt_q == 8'd0 ? S_WAIT : S_RST;
      rcnt_d  = rcnt_q == 8'd0 ? rcnt_q : rcnt_q - 8'd1;
    end else if (state_q == S_RUN && last_pix) begin
      state_d  = S_END;
      status_d = ST_OK;
      last_d   = 1'b1;
    end else if (to_hit) begin
      state_d  = S_END;
      status_d = ST_TO;
    end else if (state_q == S_RUN && stalled && stall_q) begin
      state_d  = S_END;
      status_d = ST_UR;
    end else if (state_q == S_RUN) stall_d = stalled;
    else if (!DEC_IDLE || DEC_VALID) state_d = S_RUN;
    // watchdog restarts on every state change so WAIT and RUN each get a full window
    wd_d  = !active || DEC_VALID || state_d != state_q ? '0 : wd_inc;
    irq_d = state_d == S_END || (irq_q && !IRQ_CLR);
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      wd_q      <= '0;
      pix_cnt_q <= '0;
      status_q  <= ST_OK;
      stall_q   <= 1'b0;
      irq_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      wd_q      <= wd_d;
      pix_cnt_q <= pix_cnt_d;
      status_q  <= status_d;
      stall_q   <= stall_d;
      irq_q     <= irq_d;
      last_q    <= last_d;
    end
  end
  assign DEC_RSTN   = active;
  assign BUSY       = state_q != S_IDLE;
  assign DONE       = state_q == S_END;
  assign STATUS     = status_q;
  assign IRQ        = irq_q;
  assign PIX_CNT    = pix_cnt_q;
  assign FRAME_LAST = last_q;
endmodule

// File: tb/tb_aq_djpeg_seq.sv
// tb_aq_djpeg_seq: randomized frame scenarios checked against expectations derived from the sequencer's frame rules
module tb_aq_djpeg_seq;
  localparam int RC = 4;
  localparam int TW = 24;
  logic ACLK = 1'b0, ARESETN = 1'b0, START = 1'b0, ABORT = 1'b0, IRQ_CLR = 1'b0;
  logic DEC_IDLE = 1'b1, DEC_VALID = 1'b0;
  logic [TW-1:0] TIMEOUT_LIMIT = '0;
  logic [15:0] DEC_WIDTH = 16'd8, DEC_HEIGHT = 16'd8, DEC_PIXELX = '0, DEC_PIXELY = '0;
  logic DEC_RSTN, BUSY, DONE, IRQ, FRAME_LAST;
  logic [1:0] STATUS;
  logic [31:0] PIX_CNT;
  int n_checks = 0, n_fail = 0, cyc_n = 0, done_seen = 0;

  aq_djpeg_seq #(.RST_CYCLES(RC), .TO_W(TW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .ABORT(ABORT),
    .TIMEOUT_LIMIT(TIMEOUT_LIMIT), .IRQ_CLR(IRQ_CLR), .DEC_RSTN(DEC_RSTN),
    .DEC_IDLE(DEC_IDLE), .DEC_VALID(DEC_VALID), .DEC_WIDTH(DEC_WIDTH),
    .DEC_HEIGHT(DEC_HEIGHT), .DEC_PIXELX(DEC_PIXELX), .DEC_PIXELY(DEC_PIXELY),
    .BUSY(BUSY), .DONE(DONE), .STATUS(STATUS), .IRQ(IRQ), .PIX_CNT(PIX_CNT),
    .FRAME_LAST(FRAME_LAST)
  );

  always #5 ACLK = ~ACLK;
  always @(negedge ACLK) if (DONE === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge ACLK);
    #1;
    cyc_n++;
  endtask

  task automatic gap(input int n);
    DEC_VALID = 1'b0;
    DEC_IDLE  = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic pix_at(input logic [15:0] x, input logic [15:0] y);
    DEC_VALID  = 1'b1;
    DEC_IDLE   = 1'b0;
    DEC_PIXELX = x;
    DEC_PIXELY = y;
    cyc();
    DEC_VALID = 1'b0;
  endtask

  task automatic stream(input int first, input int n, input int mg);
    int w;
    w = int'(DEC_WIDTH);
    for (int k = first; k < first + n; k++) begin
      gap(int'($urandom_range(mg)));
      pix_at(16'(k % w), 16'(k / w));
    end
  endtask

  task automatic start_frame();
    START = 1'b1;
    cyc();
    START = 1'b0;
    repeat (RC) cyc();
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && DONE !== 1'b1; i++) cyc();
  endtask

  task automatic irq_clear();
    IRQ_CLR = 1'b1;
    cyc();
    IRQ_CLR = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if ({DEC_RSTN, BUSY, DONE, STATUS, IRQ, FRAME_LAST} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000", {DEC_RSTN, BUSY, DONE, STATUS, IRQ, FRAME_LAST});
    end
    n_checks++;
    if (PIX_CNT !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pix_cnt: got %0d want 0", PIX_CNT);
    end
    ARESETN = 1'b1;
    cyc();
    ABORT = 1'b1;
    repeat (2) cyc();
    ABORT = 1'b0;
    cyc();
    n_checks++;
    if (BUSY !== 1'b0 || done_seen != 0) begin
      n_fail++;
      $display("FAIL idle_abort: got busy=%b dones=%0d want busy=0 dones=0", BUSY, done_seen);
    end
  endtask

  task automatic test_frame_ok();
    int lo, busy_bad, d0;
    DEC_WIDTH = 16'd8;
    DEC_HEIGHT = 16'd8;
    TIMEOUT_LIMIT = TW'(100);
    DEC_IDLE = 1'b1;
    d0 = done_seen;
    lo = 0;
    busy_bad = 0;
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int i = 0; i < RC + 3; i++) begin
      if (DEC_RSTN === 1'b0) lo++;
      if (BUSY !== 1'b1) busy_bad++;
      cyc();
    end
    n_checks++;
    if (lo != RC) begin
      n_fail++;
      $display("FAIL rst_window: got %0d low cycles want %0d", lo, RC);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL busy_after_start: got %0d low cycles want 0", busy_bad);
    end
    stream(0, 40, 3);
    n_checks++;
    if (PIX_CNT !== 32'd40) begin
      n_fail++;
      $display("FAIL mid_pix_cnt: got %0d want 40", PIX_CNT);
    end
    stream(40, 24, 3);
    n_checks++;
    if ({DONE, IRQ, FRAME_LAST, DEC_RSTN} !== 4'b1110 || STATUS !== 2'd0 || PIX_CNT !== 32'd64) begin
      n_fail++;
      $display("FAIL frame_end: got done/irq/last/rstn=%b status=%0d pix=%0d want 1110 status=0 pix=64",
               {DONE, IRQ, FRAME_LAST, DEC_RSTN}, STATUS, PIX_CNT);
    end
    DEC_IDLE = 1'b1;
    cyc();
    n_checks++;
    if ({BUSY, DONE, FRAME_LAST, IRQ} !== 4'b0001) begin
      n_fail++;
      $display("FAIL frame_after: got busy/done/last/irq=%b want 0001", {BUSY, DONE, FRAME_LAST, IRQ});
    end
    repeat (3) cyc();
    irq_clear();
    n_checks++;
    if (IRQ !== 1'b0 || done_seen - d0 != 1) begin
      n_fail++;
      $display("FAIL irq_clr_single_done: got irq=%b dones=%0d want irq=0 dones=1", IRQ, done_seen - d0);
    end
  endtask

  task automatic test_wrap_boundary();
    DEC_WIDTH = 16'd0;
    DEC_HEIGHT = 16'd1;
    TIMEOUT_LIMIT = TW'(100);
    start_frame();
    pix_at(16'd0, 16'd0);
    n_checks++;
    if (DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_early: got done=%b want 0", DONE);
    end
    pix_at(16'hFFFF, 16'd0);
    n_checks++;
    if (DONE !== 1'b1 || FRAME_LAST !== 1'b1 || STATUS !== 2'd0 || PIX_CNT !== 32'd2) begin
      n_fail++;
      $display("FAIL wrap_last: got done=%b last=%b status=%0d pix=%0d want 1 1 0 2", DONE, FRAME_LAST, STATUS, PIX_CNT);
    end
    DEC_IDLE = 1'b1;
    cyc();
  endtask

  task automatic test_timeout();
    int lim, n, pv, d0;
    DEC_WIDTH = 16'd8;
    DEC_HEIGHT = 16'd8;
    for (int r = 0; r < 4; r++) begin
      lim = r == 0 ? 100 : (r == 1 ? 1 : int'($urandom_range(40, 2)));
      n = r == 0 ? 10 : int'($urandom_range(20, 1));
      TIMEOUT_LIMIT = TW'(lim);
      DEC_IDLE = 1'b1;
      start_frame();
      stream(0, n, lim - 1 > 3 ? 3 : lim - 1);
      pv = cyc_n - 1;
      DEC_VALID = 1'b0;
      DEC_IDLE = 1'b0;
      wait_done(lim + 50);
      n_checks++;
      if (DONE !== 1'b1 || cyc_n - pv != lim + 1) begin
        n_fail++;
        $display("FAIL timeout_latency[%0d]: got done=%b after %0d cycles want done=1 after %0d", r, DONE, cyc_n - pv, lim + 1);
      end
      n_checks++;
      if (STATUS !== 2'd1 || PIX_CNT !== 32'(n) || DEC_RSTN !== 1'b0 || FRAME_LAST !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_status[%0d]: got status=%0d pix=%0d rstn=%b last=%b want 1 %0d 0 0",
                 r, STATUS, PIX_CNT, DEC_RSTN, FRAME_LAST, n);
      end
      DEC_IDLE = 1'b1;
      cyc();
    end
    TIMEOUT_LIMIT = '0;
    start_frame();
    stream(0, 3, 2);
    DEC_IDLE = 1'b0;
    d0 = done_seen;
    repeat (300) cyc();
    n_checks++;
    if (BUSY !== 1'b1 || done_seen != d0) begin
      n_fail++;
      $display("FAIL timeout_disabled: got busy=%b dones=%0d want busy=1 dones=0", BUSY, done_seen - d0);
    end
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    n_checks++;
    if (DONE !== 1'b1 || STATUS !== 2'd3) begin
      n_fail++;
      $display("FAIL abort_run: got done=%b status=%0d want 1 3", DONE, STATUS);
    end
    DEC_IDLE = 1'b1;
    cyc();
  endtask

  task automatic test_underrun();
    int d0;
    DEC_WIDTH = 16'd8;
    DEC_HEIGHT = 16'd8;
    TIMEOUT_LIMIT = TW'(100);
    DEC_IDLE = 1'b1;
    d0 = done_seen;
    start_frame();
    stream(0, 5, 3);
    DEC_IDLE = 1'b1;
    DEC_VALID = 1'b0;
    cyc();
    stream(5, 25, 3);
    n_checks++;
    if (BUSY !== 1'b1 || done_seen != d0) begin
      n_fail++;
      $display("FAIL underrun_glitch: got busy=%b dones=%0d want busy=1 dones=0", BUSY, done_seen - d0);
    end
    DEC_IDLE = 1'b1;
    DEC_VALID = 1'b0;
    cyc();
    n_checks++;
    if (DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_early: got done=%b want 0", DONE);
    end
    cyc();
    n_checks++;
    if (DONE !== 1'b1 || STATUS !== 2'd2 || PIX_CNT !== 32'd30) begin
      n_fail++;
      $display("FAIL underrun_end: got done=%b status=%0d pix=%0d want 1 2 30", DONE, STATUS, PIX_CNT);
    end
    cyc();
  endtask

  task automatic test_abort();
    int d0;
    DEC_WIDTH = 16'd8;
    DEC_HEIGHT = 16'd8;
    TIMEOUT_LIMIT = TW'(100);
    DEC_IDLE = 1'b1;
    irq_clear();
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear_idle: got %b want 0", IRQ);
    end
    d0 = done_seen;
    start_frame();
    stream(0, 63, 3);
    ABORT = 1'b1;
    IRQ_CLR = 1'b1;
    pix_at(16'd7, 16'd7);
    ABORT = 1'b0;
    IRQ_CLR = 1'b0;
    n_checks++;
    if ({DONE, IRQ, FRAME_LAST} !== 3'b110 || STATUS !== 2'd3) begin
      n_fail++;
      $display("FAIL abort_last: got done/irq/last=%b status=%0d want 110 status=3", {DONE, IRQ, FRAME_LAST}, STATUS);
    end
    DEC_IDLE = 1'b1;
    repeat (4) cyc();
    n_checks++;
    if (done_seen - d0 != 1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_single_done: got dones=%0d busy=%b want 1 0", done_seen - d0, BUSY);
    end
    START = 1'b1;
    cyc();
    START = 1'b0;
    cyc();
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    n_checks++;
    if (DONE !== 1'b1 || STATUS !== 2'd3 || DEC_RSTN !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rst: got done=%b status=%0d rstn=%b want 1 3 0", DONE, STATUS, DEC_RSTN);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int w, h;
    TIMEOUT_LIMIT = TW'(100);
    DEC_IDLE = 1'b1;
    start_frame();
    for (int f = 0; f < 3; f++) begin
      w = int'($urandom_range(9, 2));
      h = int'($urandom_range(9, 1));
      DEC_WIDTH = 16'(w);
      DEC_HEIGHT = 16'(h);
      stream(0, w * h, 2);
      n_checks++;
      if (DONE !== 1'b1 || FRAME_LAST !== 1'b1 || STATUS !== 2'd0 || PIX_CNT !== 32'(w * h)) begin
        n_fail++;
        $display("FAIL b2b_end[%0d]: got done=%b last=%b status=%0d pix=%0d want 1 1 0 %0d",
                 f, DONE, FRAME_LAST, STATUS, PIX_CNT, w * h);
      end
      START = 1'b1;
      cyc();
      n_checks++;
      if (BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_start_in_end[%0d]: got busy=%b want 0", f, BUSY);
      end
      cyc();
      START = 1'b0;
      n_checks++;
      if (BUSY !== 1'b1 || STATUS !== 2'd0 || PIX_CNT !== 32'd0 || DEC_RSTN !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_restart[%0d]: got busy=%b status=%0d pix=%0d rstn=%b want 1 0 0 0",
                 f, BUSY, STATUS, PIX_CNT, DEC_RSTN);
      end
      repeat (RC) cyc();
    end
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    DEC_IDLE = 1'b1;
    cyc();
  endtask

  task automatic test_start_ignored_reset();
    int d0;
    DEC_WIDTH = 16'd8;
    DEC_HEIGHT = 16'd8;
    TIMEOUT_LIMIT = TW'(100);
    DEC_IDLE = 1'b1;
    irq_clear();
    start_frame();
    stream(0, 20, 3);
    START = 1'b1;
    pix_at(16'd4, 16'd2);
    START = 1'b0;
    stream(21, 4, 3);
    n_checks++;
    if (PIX_CNT !== 32'd25 || BUSY !== 1'b1 || DEC_RSTN !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run: got pix=%0d busy=%b rstn=%b want 25 1 1", PIX_CNT, BUSY, DEC_RSTN);
    end
    d0 = done_seen;
    #2;
    ARESETN = 1'b0;
    #1;
    n_checks++;
    if ({DEC_RSTN, BUSY, DONE, STATUS, IRQ, FRAME_LAST} !== 7'b0 || PIX_CNT !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got flags=%b pix=%0d want 0000000 pix=0",
               {DEC_RSTN, BUSY, DONE, STATUS, IRQ, FRAME_LAST}, PIX_CNT);
    end
    repeat (2) cyc();
    ARESETN = 1'b1;
    DEC_IDLE = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (done_seen != d0 || IRQ !== 1'b0 || BUSY !== 1'b0 || DEC_RSTN !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got dones=%0d irq=%b busy=%b rstn=%b want 0 0 0 0", done_seen - d0, IRQ, BUSY, DEC_RSTN);
    end
  endtask

  initial begin
    test_reset();
    test_frame_ok();
    test_wrap_boundary();
    test_timeout();
    test_underrun();
    test_abort();
    test_back_to_back();
    test_start_ignored_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
